bt_uart_tx_ctrl: RTL
====================

Name: bt_uart_tx_ctrl

Overview:
- Sequences an 8-bit parallel-to-serial shift datapath into a UART frame for the Bluetooth serial module (HC-05 class link, idle-high line).
- Accepts a byte via valid/ready handshake and generates the bit-period timing.
- Frame order: start bit, data LSB first, stop bit(s); one-cycle done pulse at end of frame.
- Sits between the application byte source and the Bluetooth module's RX pin.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit period (50 MHz / 9600 baud); legal range >= 2.
- DATA_BITS, 8, payload bits per frame; legal range 5..8.
- STOP_BITS, 1, number of stop-bit periods; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  requester has a byte.
- tx_ready  output  1  block can accept a byte (high only in IDLE).
- tx  output  1  serial line to the Bluetooth module.
- busy  output  1  frame in progress (START, DATA or STOP state).
- done  output  1  single-cycle pulse on the last cycle of the final stop period.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, tx=1, tx_ready=1, busy=0, done=0.
  - Bit counter, baud counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 on the next cycle; no done pulse.
- All outputs are registered.
- States:
  - IDLE: tx=1. If tx_valid && tx_ready at posedge:
    - shift_reg <= tx_data; go to START; tx_ready<=0; busy<=1.
    - tx goes low on the cycle after the handshake (latency 1).
  - START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA:
    - tx = shift_reg[0], held CLKS_PER_BIT cycles.
    - At end of period: shift_reg >>= 1; bit_idx++.
    - After bit_idx reaches DATA_BITS-1 and its period ends, go to STOP.
  - STOP:
    - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - done=1 on the final cycle of the stop period.
    - Next cycle: IDLE, tx_ready=1, busy=0.
- Frame length: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles from first low tx cycle to tx_ready re-asserting.
- Back-to-back: tx_valid held high means a new handshake on the first IDLE cycle. Minimum one IDLE cycle (tx=1) between frames.
- tx_valid while busy is ignored; tx_data changes during a frame do not affect the frame in flight.
- Baud counter:
  - Width clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and emits a one-cycle bit_tick.
  - Cleared on handshake so the first period is exact.
- bit_idx width clog2(DATA_BITS)+1; no wrap beyond DATA_BITS-1.

Decomposition:
- Package bt_uart_pkg contains:
  - state enum tx_state_t {IDLE, START, DATA, STOP};
  - default constants CLK_HZ=50_000_000 and BAUD=9600;
  - a CLKS_PER_BIT derivation function.
- One sub-module, bt_baud_gen:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst, clear, en; output bit_tick.
  - Reused later by the matching RX controller.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless noted):
1. Reset, then idle 20 cycles -> tx=1, tx_ready=1, busy=0, done=0 throughout.
2. Send 8'hE3 -> tx sequence, each level held 4 cycles: 0 (start), then 1,1,0,0,0,1,1,1 (LSB first), then 1 (stop). done high once on cycle 40 after first low; tx_ready high on cycle 41.
3. tx_valid held high with 8'h55 then 8'hAA -> two frames of 40 cycles each separated by exactly one IDLE cycle of tx=1. tx_data toggled mid-frame does not corrupt either frame.
4. STOP_BITS=2, send 8'h00 -> start period plus 8 zero periods (36 low cycles), then 8 high cycles; done on the last one.
5. Assert rst for one cycle during data bit 3 of 8'hF0 -> next cycle tx=1, tx_ready=1, busy=0; no done pulse. A subsequent 8'h0F frame is transmitted correctly.
6. Pulse tx_valid during a frame while busy=1 -> no handshake; frame bits unchanged; no second frame follows.

Source files
------------

// File: rtl/bt_uart_pkg.sv
// Shared types and timing constants for the Bluetooth serial-link UART blocks.
// No logic: a state enum, default link constants and a bit-period helper.
// Imported by the TX controller, its baud generator and the matching RX side.
package bt_uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int CLK_HZ = 50_000_000;
   localparam int BAUD   = 9600;

   // Clock cycles per bit period, rounded to the nearest whole cycle.
   function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + (baud / 2)) / baud;
   endfunction

endpackage

// File: rtl/bt_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes bit_tick on the wrap cycle.
// Latency: bit_tick is combinational from the count; clear restarts the period next cycle.
// Backpressure: none; counting stalls while en is low.
module bt_baud_gen #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic bit_tick,
   output logic pre_tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] cnt;

   // Period counter; clear aligns the first period exactly to the handshake.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   // pre_tick fires one cycle ahead of bit_tick so callers can register
   // a strobe that lines up with the final cycle of a period.
   assign bit_tick = en && (cnt == LAST);
   assign pre_tick = en && (cnt == PRE);

endmodule

// File: rtl/bt_uart_tx_ctrl.sv
// UART frame sequencer for the Bluetooth module RX pin: start, LSB-first data, stop bit(s).
// Latency: tx drops low on the cycle after the handshake; frame is (1+DATA_BITS+STOP_BITS) bit periods.
// Backpressure: tx_ready is high only in IDLE; tx_valid and tx_data are ignored while busy.
module bt_uart_tx_ctrl
   import bt_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD),
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int BW = $clog2(DATA_BITS) + 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_t            state, state_n;
   logic [DATA_BITS-1:0] shift_reg, shift_n;
   logic [BW-1:0]        bit_idx, bit_idx_n;
   logic                 stop_idx, stop_n;
   logic                 tx_n, ready_n, busy_n, done_n;
   logic                 handshake;
   logic                 bit_tick, pre_tick;

   bt_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (handshake),
      .en       (busy),
      .bit_tick (bit_tick),
      .pre_tick (pre_tick)
   );

   // State, datapath and registered outputs; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         tx        <= 1'b1;
         tx_ready  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         shift_reg <= shift_n;
         bit_idx   <= bit_idx_n;
         stop_idx  <= stop_n;
         tx        <= tx_n;
         tx_ready  <= ready_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

   // Next state and next output values; outputs are computed one cycle early
   // so that every port comes straight from a flop.
   always_comb begin
      state_n   = state;
      shift_n   = shift_reg;
      bit_idx_n = bit_idx;
      stop_n    = stop_idx;
      tx_n      = 1'b1;
      ready_n   = 1'b0;
      busy_n    = 1'b1;
      done_n    = 1'b0;
      handshake = 1'b0;

      case (state)
         IDLE: begin
            ready_n = 1'b1;
            busy_n  = 1'b0;
            if (tx_valid && tx_ready) begin
               handshake = 1'b1;
               shift_n   = tx_data;
               bit_idx_n = '0;
               stop_n    = 1'b0;
               state_n   = START;
               tx_n      = 1'b0;
               ready_n   = 1'b0;
               busy_n    = 1'b1;
            end
         end

         START: begin
            tx_n = 1'b0;
            if (bit_tick) begin
               state_n   = DATA;
               bit_idx_n = '0;
               tx_n      = shift_reg[0];
            end
         end

         DATA: begin
            tx_n = shift_reg[0];
            if (bit_tick) begin
               shift_n = shift_reg >> 1;
               if (bit_idx == LAST_BIT) begin
                  state_n = STOP;
                  stop_n  = 1'b0;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + BW'(1);
                  tx_n      = shift_n[0];
               end
            end
         end

         STOP: begin
            tx_n = 1'b1;
            // Look one cycle ahead so done lands on the final stop cycle.
            if (pre_tick && (stop_idx == LAST_STOP)) begin
               done_n = 1'b1;
            end
            if (bit_tick) begin
               if (stop_idx == LAST_STOP) begin
                  state_n = IDLE;
                  ready_n = 1'b1;
                  busy_n  = 1'b0;
               end else begin
                  stop_n = 1'b1;
               end
            end
         end

         default: begin
            state_n = IDLE;
            ready_n = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule
